if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer; replaces the free-running PC register in front of instruction memory.
//  Owns the PC and picks the next PC in priority order: flush/exception vector, branch target, stall hold, PC+4.
//  Drives a req/ack instruction-memory port with variable latency, and loads the IF/ID outputs.
//  Discards fetches made stale by a redirect. Buffers one fetch that completes while decode is stalled.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded by reset; first fetch address
//  TIMEOUT   16             cycles a request may wait for ack before imem_err_o pulses (>=2)
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   reset, asynchronous, active-low
//  stall_i          in   1   decode not consuming; hold IF/ID outputs
//  branch_flag_i    in   1   branch taken this cycle
//  branch_target_i  in   32  branch destination
//  flush_i          in   1   pipeline flush / exception
//  new_pc_i         in   32  flush/exception vector
//  imem_req_o       out  1   instruction-memory request
//  imem_addr_o      out  32  request address, word aligned
//  imem_ack_i       in   1   request complete, data valid this cycle
//  imem_data_i      in   32  fetched instruction
//  imem_err_o       out  1   one-cycle pulse on ack timeout
//  ce_o             out  1   chip enable, 0 during reset and boot
//  pc_o             out  32  address of next fetch
//  if_valid_o       out  1   IF/ID holds a valid instruction
//  if_pc_o          out  32  PC of if_inst_o
//  if_inst_o        out  32  instruction to decode
// BEHAVIOUR
//  Reset (rst=0, async):
//   - pc_o=RESET_PC; ce_o=0; imem_req_o=0; imem_addr_o=0; imem_err_o=0; if_valid_o=0; if_pc_o=0; if_inst_o=0.
//   - state=BOOT; wait counter=0.
//  States: BOOT, FETCH, DISCARD, HOLD.
//  BOOT: one cycle after rst release. Then ce_o<=1, imem_req_o<=1, imem_addr_o<=pc_o, next state FETCH.
//  Bus rule: once raised, imem_req_o and imem_addr_o stay stable until the ack cycle.
//   - A zero-wait memory may ack every cycle, giving one fetch per cycle.
//  FETCH, ack, no redirect, stall_i=0:
//   - if_valid_o<=1; if_inst_o<=imem_data_i; if_pc_o<=imem_addr_o.
//   - pc_o<=pc_o+4; next request addr=pc_o+4 with req kept high.
//  FETCH, no ack, stall_i=1: if_* unchanged; request continues.
//  FETCH, ack, stall_i=1: data+addr go to skid entry; pc_o+=4; req<=0; next state HOLD.
//  HOLD: req stays 0; if_* frozen while stall_i=1.
//   - When stall_i=0: if_* <= skid; req<=1 at pc_o; next state FETCH.
//  Redirect: flush_i beats branch_flag_i. Target = new_pc_i or branch_target_i, low 2 bits forced 0.
//   - Effect: if_valid_o<=0; pc_o<=target.
//   - No request outstanding, or ack this cycle: ack data dropped; next request at target; next state FETCH.
//   - Request outstanding without ack: next state DISCARD. Request held until ack; acked data dropped.
//     Then req at pc_o; next state FETCH.
//   - Redirect while in DISCARD: overwrites pc_o, latest wins.
//   - Redirect while in HOLD: skid dropped; next state FETCH at target.
//   - A redirect overrides stall_i.
//  Timeout:
//   - Wait counter increments each cycle req=1 and ack=0; clears on ack or redirect-to-FETCH.
//   - At TIMEOUT-1: imem_err_o=1 for one cycle; counter clears; request stays up (retry).
//  Arithmetic: PC math is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
//  ce_o: 0 only in reset and BOOT.
//  Reset mid-request: everything returns to reset values at once. Any later ack is ignored until BOOT completes.
// STRUCTURE
//  define.v holds:
//   - state encodings `IfBoot/`IfFetch/`IfDiscard/`IfHold;
//   - `InstAddrBus, `InstBus, `ChipEnable/`ChipDisable;
//   - `RstEnable (1'b0 for this block).
//  Sub-module if_skid_buf: one-entry {pc,inst} register with load/clear, async active-low reset.
//  Next-PC mux and FSM stay in if_fetch_ctrl.
// TESTING
//  1. Reset release, memory acks every cycle:
//     - ce_o=0 in BOOT; first imem_addr_o=0.
//     - if_pc_o steps 0,4,8,... one per cycle.
//  2. 3-cycle ack latency, branch_flag_i=1 to 32'h100 on the 2nd wait cycle:
//     - the ack for addr 4 is dropped; if_valid_o=0 meanwhile;
//     - next imem_addr_o=32'h100.
//  3. flush_i (new_pc_i=32'h180) and branch_flag_i (32'h100) in the same cycle:
//     - pc_o=32'h180; no instruction from 32'h100 ever reaches if_*.
//  4. stall_i=1 for 4 cycles, ack arrives during the stall:
//     - if_* frozen; req=0 after the ack;
//     - on release if_* shows the buffered instruction, then fetching resumes.
//  5. Never ack, TIMEOUT=16:
//     - imem_err_o pulses after the 16th wait cycle, then every 16 cycles;
//     - req and addr stay stable throughout.
//  6. pc_o=32'hFFFF_FFFC, then ack:
//     - next addr=0; assert rst mid-request: outputs at reset values the same cycle.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_fetch_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef logic [XLEN-1:0] inst_addr_t;
  typedef logic [XLEN-1:0] inst_t;

  typedef enum logic [1:0] {
    IF_BOOT    = 2'd0,
    IF_FETCH   = 2'd1,
    IF_DISCARD = 2'd2,
    IF_HOLD    = 2'd3
  } if_state_e;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } skid_entry_t;

  // Instruction addresses are word aligned; redirect targets drop their low bits.
  function automatic inst_addr_t word_align(input inst_addr_t a);
    return a & ~inst_addr_t'(3);
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge port.
interface if_fetch_ctrl_if;
  import if_fetch_ctrl_pkg::*;

  logic       imem_req_o;
  inst_addr_t imem_addr_o;
  logic       imem_ack_i;
  inst_t      imem_data_i;
  logic       imem_err_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    output imem_err_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    input  imem_err_o,
    output imem_ack_i,
    output imem_data_i
  );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {pc,inst} holding register for a fetch that completes while decode is stalled.
module if_skid_buf
  import if_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  skid_entry_t d_i,
  output skid_entry_t q_o
);

  skid_entry_t entry_q;
  skid_entry_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (clear_i) begin
      entry_d = '0;
    end else if (load_i) begin
      entry_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the req/ack instruction-memory
// port, drops fetches made stale by redirects and loads the IF/ID outputs.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter inst_addr_t  RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             branch_flag_i,
  input  inst_addr_t       branch_target_i,
  input  logic             flush_i,
  input  inst_addr_t       new_pc_i,
  if_fetch_ctrl_if.master  imem,
  output logic             ce_o,
  output inst_addr_t       pc_o,
  output logic             if_valid_o,
  output inst_addr_t       if_pc_o,
  output inst_t            if_inst_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  if_state_e        state_q, state_d;
  inst_addr_t       pc_q, pc_d;
  logic             ce_q, ce_d;
  logic             req_q, req_d;
  inst_addr_t       addr_q, addr_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  inst_addr_t       if_pc_q, if_pc_d;
  inst_t            if_inst_q, if_inst_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  logic        skid_load;
  logic        skid_clear;
  skid_entry_t skid_in;
  skid_entry_t skid_q;

  logic       redirect;
  logic       ack;
  inst_addr_t target;
  inst_addr_t pc_inc;

  // Flush outranks branch; an ack only counts while a request is actually up.
  assign redirect = flush_i | branch_flag_i;
  assign target   = word_align(flush_i ? new_pc_i : branch_target_i);
  assign ack      = imem.imem_ack_i & req_q;
  assign pc_inc   = pc_q + inst_addr_t'(PC_STEP);
  assign skid_in  = '{pc: addr_q, inst: imem.imem_data_i};

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .d_i     (skid_in),
    .q_o     (skid_q)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    req_d      = req_q;
    addr_d     = addr_q;
    err_d      = 1'b0;
    valid_d    = valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    wcnt_d     = wcnt_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    // Ack-timeout watchdog; the request itself stays up as a retry.
    if (ack) begin
      wcnt_d = '0;
    end else if (req_q) begin
      if (wcnt_q == CNT_LAST) begin
        wcnt_d = '0;
        err_d  = 1'b1;
      end else begin
        wcnt_d = wcnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      IF_BOOT: begin
        ce_d    = CHIP_ENABLE;
        req_d   = 1'b1;
        addr_d  = pc_q;
        state_d = IF_FETCH;
        if (redirect) begin
          pc_d   = target;
          addr_d = target;
        end
      end

      IF_FETCH: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          if (ack) begin
            addr_d = target;
          end else begin
            state_d = IF_DISCARD;
          end
        end else if (ack) begin
          pc_d = pc_inc;
          if (stall_i) begin
            skid_load = 1'b1;
            req_d     = 1'b0;
            state_d   = IF_HOLD;
          end else begin
            valid_d   = 1'b1;
            if_pc_d   = addr_q;
            if_inst_d = imem.imem_data_i;
            addr_d    = pc_inc;
          end
        end else if (!stall_i) begin
          valid_d = 1'b0;
        end
      end

      // Stale request still in flight: keep the bus stable and drop its data.
      IF_DISCARD: begin
        if (redirect) begin
          pc_d = target;
          if (ack) begin
            addr_d  = target;
            state_d = IF_FETCH;
          end
        end else if (ack) begin
          addr_d  = pc_q;
          state_d = IF_FETCH;
        end
      end

      IF_HOLD: begin
        if (redirect) begin
          valid_d    = 1'b0;
          pc_d       = target;
          req_d      = 1'b1;
          addr_d     = target;
          skid_clear = 1'b1;
          state_d    = IF_FETCH;
        end else if (!stall_i) begin
          valid_d   = 1'b1;
          if_pc_d   = skid_q.pc;
          if_inst_d = skid_q.inst;
          req_d     = 1'b1;
          addr_d    = pc_q;
          state_d   = IF_FETCH;
        end
      end

      default: state_d = IF_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IF_BOOT;
      pc_q      <= RESET_PC;
      ce_q      <= CHIP_DISABLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      if_pc_q   <= '0;
      if_inst_q <= '0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ce_q      <= ce_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      wcnt_q    <= wcnt_d;
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;
  assign imem.imem_err_o  = err_q;
  assign ce_o             = ce_q;
  assign pc_o             = pc_q;
  assign if_valid_o       = valid_q;
  assign if_pc_o          = if_pc_q;
  assign if_inst_o        = if_inst_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus randomized redirects/stalls/latency
// checked against a program-order delivery model and a bus-stability monitor.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          TIMEOUT    = 16;
  localparam int          MODE_FIXED = 0;
  localparam int          MODE_RAND  = 1;
  localparam int          MODE_NEVER = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        ce_o;
  logic [31:0] pc_o;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  if_fetch_ctrl_if imem ();

  if_fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .imem            (imem),
    .ce_o            (ce_o),
    .pc_o            (pc_o),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: ack after cur_lat wait cycles of the current request.
  int mem_mode  = MODE_FIXED;
  int fixed_lat = 0;
  int cur_lat   = 0;
  int waited    = 0;
  bit force_ack = 1'b0;

  initial begin
    imem.imem_ack_i  = 1'b0;
    imem.imem_data_i = '0;
  end

  always @(negedge clk) begin
    if (force_ack) begin
      imem.imem_ack_i  = 1'b1;
      imem.imem_data_i = inst_of(imem.imem_addr_o);
    end else if (rst && imem.imem_req_o) begin
      if (waited == 0) cur_lat = (mem_mode == MODE_RAND) ? int'($urandom_range(0, 3)) : fixed_lat;
      if (mem_mode != MODE_NEVER && waited >= cur_lat) begin
        imem.imem_ack_i  = 1'b1;
        imem.imem_data_i = inst_of(imem.imem_addr_o);
        waited = 0;
      end else begin
        imem.imem_ack_i  = 1'b0;
        imem.imem_data_i = $urandom;
        waited++;
      end
    end else begin
      imem.imem_ack_i  = 1'b0;
      imem.imem_data_i = '0;
      waited = 0;
    end
  end

  // Delivery model: decode must see instructions in program order from the
  // latest redirect target, each carrying the memory word of its own PC.
  logic [31:0] exp_pc = RESET_PC;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          consumed = 0;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      exp_pc = RESET_PC;
      pend   = 1'b0;
    end else begin
      if (pend) begin
        vectors++;
        if (imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== pend_addr) begin
          miscompares++;
          $display("FAIL bus_hold: req=%b addr=%h expected req=1 addr=%h", imem.imem_req_o, imem.imem_addr_o, pend_addr);
        end
      end
      if (flush_i || branch_flag_i) begin
        exp_pc = (flush_i ? new_pc_i : branch_target_i) & ~32'h3;
      end else if (if_valid_o && !stall_i) begin
        vectors++;
        if (if_pc_o !== exp_pc || if_inst_o !== inst_of(exp_pc)) begin
          miscompares++;
          $display("FAIL delivery: pc=%h inst=%h expected pc=%h inst=%h", if_pc_o, if_inst_o, exp_pc, inst_of(exp_pc));
        end
        consumed++;
        exp_pc = exp_pc + 32'd4;
      end
      pend      = imem.imem_req_o && !imem.imem_ack_i;
      pend_addr = imem.imem_addr_o;
    end
  end

  // Leaves the bench in the BOOT cycle, just after reset release.
  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++;
    if ({ce_o, imem.imem_req_o, imem.imem_err_o, if_valid_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: ce/req/err/valid=%b expected 0000", {ce_o, imem.imem_req_o, imem.imem_err_o, if_valid_o});
    end
    vectors++;
    if ({pc_o, imem.imem_addr_o, if_pc_o, if_inst_o} !== {RESET_PC, 96'h0}) begin
      miscompares++;
      $display("FAIL reset_data: pc/addr/if_pc/if_inst=%h expected %h", {pc_o, imem.imem_addr_o, if_pc_o, if_inst_o}, {RESET_PC, 96'h0});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (ce_o !== 1'b0 || imem.imem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_idle: ce=%b req=%b expected 0 0", ce_o, imem.imem_req_o);
    end
    @(negedge clk); #1;
    vectors++;
    if (ce_o !== 1'b1 || imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== RESET_PC) begin
      miscompares++;
      $display("FAIL boot_exit: ce=%b req=%b addr=%h expected 1 1 %h", ce_o, imem.imem_req_o, imem.imem_addr_o, RESET_PC);
    end
  endtask

  task automatic test_seq_fetch();
    mem_mode = MODE_FIXED; fixed_lat = 0;
    do_reset();
    vectors++;
    if (ce_o !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_boot_ce: got %b expected 0", ce_o);
    end
    @(negedge clk); #1;
    vectors++;
    if (imem.imem_addr_o !== RESET_PC || imem.imem_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_first_addr: addr=%h req=%b expected %h 1", imem.imem_addr_o, imem.imem_req_o, RESET_PC);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'(4 * i) || imem.imem_addr_o !== 32'(4 * (i + 1))) begin
        miscompares++;
        $display("FAIL seq_step[%0d]: valid=%b if_pc=%h addr=%h expected 1 %h %h", i, if_valid_o, if_pc_o, imem.imem_addr_o, 32'(4 * i), 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_branch_latency();
    mem_mode = MODE_FIXED; fixed_lat = 3;
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk); #1;
      branch_flag_i = (c == 6); branch_target_i = 32'h100;
      if (c == 5) begin
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0) begin
          miscompares++;
          $display("FAIL br_first: valid=%b if_pc=%h expected 1 0", if_valid_o, if_pc_o);
        end
      end
      if (c >= 6 && c <= 12) begin
        vectors++;
        if (if_valid_o !== 1'b0) begin
          miscompares++;
          $display("FAIL br_invalid[%0d]: valid=%b expected 0", c, if_valid_o);
        end
      end
      if (c == 7) begin
        vectors++;
        if (pc_o !== 32'h100 || imem.imem_addr_o !== 32'h4 || imem.imem_req_o !== 1'b1) begin
          miscompares++;
          $display("FAIL br_discard: pc=%h addr=%h req=%b expected 100 4 1", pc_o, imem.imem_addr_o, imem.imem_req_o);
        end
      end
      if (c == 8) begin
        vectors++;
        if (imem.imem_ack_i !== 1'b1 || imem.imem_addr_o !== 32'h4) begin
          miscompares++;
          $display("FAIL br_stale_ack: ack=%b addr=%h expected 1 4", imem.imem_ack_i, imem.imem_addr_o);
        end
      end
      if (c == 9) begin
        vectors++;
        if (imem.imem_addr_o !== 32'h100 || imem.imem_req_o !== 1'b1) begin
          miscompares++;
          $display("FAIL br_new_req: addr=%h req=%b expected 100 1", imem.imem_addr_o, imem.imem_req_o);
        end
      end
      if (c == 13) begin
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || if_inst_o !== inst_of(32'h100)) begin
          miscompares++;
          $display("FAIL br_target: valid=%b if_pc=%h inst=%h expected 1 100 %h", if_valid_o, if_pc_o, if_inst_o, inst_of(32'h100));
        end
      end
    end
  endtask

  task automatic test_flush_priority();
    mem_mode = MODE_FIXED; fixed_lat = 0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      flush_i = (c == 2); new_pc_i = 32'h180;
      branch_flag_i = (c == 2); branch_target_i = 32'h100;
      if (c == 3) begin
        vectors++;
        if (pc_o !== 32'h180 || imem.imem_addr_o !== 32'h180 || if_valid_o !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_pc: pc=%h addr=%h valid=%b expected 180 180 0", pc_o, imem.imem_addr_o, if_valid_o);
        end
      end
      if (c >= 4) begin
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'(32'h180 + 4 * (c - 4))) begin
          miscompares++;
          $display("FAIL flush_stream[%0d]: valid=%b if_pc=%h expected 1 %h", c, if_valid_o, if_pc_o, 32'(32'h180 + 4 * (c - 4)));
        end
      end
    end
  endtask

  task automatic test_stall_skid();
    mem_mode = MODE_FIXED; fixed_lat = 2;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      stall_i = (c >= 4 && c <= 7);
      if (c >= 4 && c <= 8) begin
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_inst_o !== inst_of(32'h0)) begin
          miscompares++;
          $display("FAIL stall_frozen[%0d]: valid=%b if_pc=%h expected 1 0", c, if_valid_o, if_pc_o);
        end
      end
      if (c == 7 || c == 8) begin
        vectors++;
        if (imem.imem_req_o !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_req_low[%0d]: req=%b expected 0", c, imem.imem_req_o);
        end
      end
      if (c == 9) begin
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h4 || if_inst_o !== inst_of(32'h4) ||
            imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== 32'h8) begin
          miscompares++;
          $display("FAIL stall_release: valid=%b if_pc=%h inst=%h req=%b addr=%h expected 1 4 %h 1 8",
                   if_valid_o, if_pc_o, if_inst_o, imem.imem_req_o, imem.imem_addr_o, inst_of(32'h4));
        end
      end
      if (c == 12) begin
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8) begin
          miscompares++;
          $display("FAIL stall_resume: valid=%b if_pc=%h expected 1 8", if_valid_o, if_pc_o);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit exp_err;
    mem_mode = MODE_NEVER;
    do_reset();
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk); #1;
      exp_err = (c >= TIMEOUT + 1) && ((c - (TIMEOUT + 1)) % TIMEOUT == 0);
      vectors++;
      if (imem.imem_err_o !== exp_err || imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== RESET_PC) begin
        miscompares++;
        $display("FAIL timeout[%0d]: err=%b req=%b addr=%h expected %b 1 %h", c, imem.imem_err_o, imem.imem_req_o, imem.imem_addr_o, exp_err, RESET_PC);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    mem_mode = MODE_FIXED; fixed_lat = 0;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      flush_i = (c == 1); new_pc_i = 32'hFFFF_FFFC;
      if (c == 2) fixed_lat = 5;
      if (c == 3) begin
        vectors++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC || imem.imem_addr_o !== 32'h0 ||
            pc_o !== 32'h0 || imem.imem_req_o !== 1'b1) begin
          miscompares++;
          $display("FAIL wrap: valid=%b if_pc=%h addr=%h pc=%h req=%b expected 1 fffffffc 0 0 1",
                   if_valid_o, if_pc_o, imem.imem_addr_o, pc_o, imem.imem_req_o);
        end
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({ce_o, imem.imem_req_o, imem.imem_err_o, if_valid_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreq_ctrl: ce/req/err/valid=%b expected 0000", {ce_o, imem.imem_req_o, imem.imem_err_o, if_valid_o});
    end
    vectors++;
    if ({pc_o, imem.imem_addr_o, if_pc_o, if_inst_o} !== {RESET_PC, 96'h0}) begin
      miscompares++;
      $display("FAIL midreq_data: pc/addr/if_pc/if_inst=%h expected %h", {pc_o, imem.imem_addr_o, if_pc_o, if_inst_o}, {RESET_PC, 96'h0});
    end
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    force_ack = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (if_valid_o !== 1'b0 || ce_o !== 1'b1 || imem.imem_req_o !== 1'b1 || imem.imem_addr_o !== RESET_PC) begin
      miscompares++;
      $display("FAIL boot_ack_ignored: valid=%b ce=%b req=%b addr=%h expected 0 1 1 %h", if_valid_o, ce_o, imem.imem_req_o, imem.imem_addr_o, RESET_PC);
    end
  endtask

  task automatic test_random();
    int start;
    int r;
    mem_mode = MODE_RAND;
    do_reset();
    start = consumed;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      r = int'($urandom_range(0, 99));
      stall_i         = ($urandom_range(0, 3) == 0);
      flush_i         = (r < 4);
      branch_flag_i   = (r < 2) || (r >= 4 && r < 10);
      new_pc_i        = $urandom & 32'h0000_0FFF;
      branch_target_i = $urandom & 32'h0000_0FFF;
    end
    @(negedge clk); #1;
    stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    vectors++;
    if (consumed - start < 150) begin
      miscompares++;
      $display("FAIL random_progress: delivered %0d expected at least 150", consumed - start);
    end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_branch_latency();
    test_flush_priority();
    test_stall_skid();
    test_timeout();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
